// File: rtl/soc2_axi_timer.sv
`timescale 1ns/1ps
// soc2_axi_timer
// AXI4-lite memory-mapped 32-bit timer for the soc2 system. It has a prescaled
// up-counter that either runs freely or reloads automatically, a compare register
// with a sticky match flag, and a registered level interrupt.
//
// Register map (word offsets, address bits [ADDR_W-1:4] must be zero):
//   0x0 CTRL    : [0] en, [1] irq_en, [2] auto_reload, [15:8] prescale
//   0x4 COUNT   : 32-bit counter, read/write
//   0x8 COMPARE : 32-bit compare value, read/write
//   0xC STATUS  : [0] match, write 1 to clear
//
// Ports:
//   clk, resetn            clock and asynchronous active-low reset
//   s_aw*, s_w*, s_b*      AXI4-lite write address, write data and write response
//   s_ar*, s_r*            AXI4-lite read address and read data
//   timer_irq              registered STATUS.match & CTRL.irq_en
module soc2_axi_timer #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              timer_irq
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Register state
    logic        en;
    logic        irq_en;
    logic        auto_reload;
    logic [7:0]  prescale;
    logic [31:0] count;
    logic [31:0] compare;
    logic        match;
    logic [7:0]  pcnt;
    logic [31:0] ctrl_word;

    // Write channel state
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic              aw_fire;
    logic              w_fire;
    logic              wr_commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_err;
    logic              wr_ok;
    reg_sel_e          wr_sel;
    logic              wr_ctrl;
    logic              wr_count;
    logic              wr_compare;
    logic              wr_clear;
    logic [31:0]       ctrl_new;

    // Read path
    logic              rd_err;
    logic [31:0]       rd_word;

    // Counter path
    logic        tick;
    logic        hit;
    logic [31:0] count_tick;

    assign s_awready = ~aw_held & ~s_bvalid;
    assign s_wready  = ~w_held & ~s_bvalid;
    assign s_arready = ~s_rvalid;

    always_comb begin
        ctrl_word = {16'b0, prescale, 5'b0, auto_reload, irq_en, en};
    end

    // A side captured in an earlier cycle is used from its holding register,
    // otherwise straight from the bus, so the commit happens in the first cycle
    // in which both address and data are available.
    always_comb begin
        aw_fire    = s_awvalid & s_awready;
        w_fire     = s_wvalid & s_wready;
        wr_addr    = aw_held ? aw_addr_q : s_awaddr;
        wr_data    = w_held ? w_data_q : s_wdata;
        wr_strb    = w_held ? w_strb_q : s_wstrb;
        wr_commit  = (aw_held | aw_fire) & (w_held | w_fire);
        wr_err     = |wr_addr[ADDR_W-1:4];
        wr_ok      = wr_commit & ~wr_err;
        wr_sel     = reg_sel_e'(wr_addr[3:2]);
        wr_ctrl    = wr_ok & (wr_sel == REG_CTRL);
        wr_count   = wr_ok & (wr_sel == REG_COUNT);
        wr_compare = wr_ok & (wr_sel == REG_COMPARE);
        wr_clear   = wr_ok & (wr_sel == REG_STATUS) & wr_strb[0] & wr_data[0];
        ctrl_new   = byte_merge(ctrl_word, wr_data, wr_strb);
    end

    always_comb begin
        rd_err  = |s_araddr[ADDR_W-1:4];
        rd_word = '0;
        case (reg_sel_e'(s_araddr[3:2]))
            REG_CTRL:    rd_word = ctrl_word;
            REG_COUNT:   rd_word = count;
            REG_COMPARE: rd_word = compare;
            REG_STATUS:  rd_word = {31'b0, match};
            default:     rd_word = '0;
        endcase
    end

    always_comb begin
        tick       = en & (pcnt == prescale);
        hit        = tick & (count == compare);
        count_tick = count;
        if (tick) count_tick = (hit & auto_reload) ? '0 : count + 32'd1;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, s_araddr[1:0], wr_addr[1:0], ctrl_new[31:16], ctrl_new[7:3]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s_bvalid  <= 1'b0;
            s_bresp   <= RESP_OKAY;
        end else if (s_bvalid) begin
            if (s_bready) s_bvalid <= 1'b0;
        end else if (wr_commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bvalid <= 1'b1;
            s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (s_rvalid) begin
            if (s_rready) s_rvalid <= 1'b0;
        end else if (s_arvalid) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_err ? '0 : rd_word;
            s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            prescale    <= '0;
            count       <= '0;
            compare     <= '0;
            match       <= 1'b0;
            pcnt        <= '0;
            timer_irq   <= 1'b0;
        end else begin
            if (!en || tick) pcnt <= '0;
            else             pcnt <= pcnt + 8'd1;

            // Bus write wins over the tick; unstrobed bytes keep the ticked value.
            count <= wr_count ? byte_merge(count_tick, wr_data, wr_strb) : count_tick;

            if (wr_compare) compare <= byte_merge(compare, wr_data, wr_strb);

            if (wr_ctrl) begin
                en          <= ctrl_new[0];
                irq_en      <= ctrl_new[1];
                auto_reload <= ctrl_new[2];
                prescale    <= ctrl_new[15:8];
            end

            // A new match takes priority over a simultaneous write-1-to-clear.
            match     <= hit | (match & ~wr_clear);
            timer_irq <= match & irq_en;
        end
    end

endmodule

// File: tb/tb_soc2_axi_timer.sv
`timescale 1ns/1ps
module tb_soc2_axi_timer;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [15:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic        timer_irq;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    soc2_axi_timer #(.ADDR_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .timer_irq(timer_irq)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Number of tick cycles in [lo, hi] for a counter enabled from cycle e
    // with prescale p: ticks fall on cycles e+p, e+2p+1, ...
    function automatic int ticks(input int e, input int p, input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (c >= e && ((c - e) % (p + 1)) == p) n++;
        return n;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic wait_until(input int t);
        int n = 0;
        while (cyc < t && n < 500) begin @(negedge clk); n++; end
    endtask

    // Returns bcyc = first cycle in which the write is visible (bvalid high).
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp, output int bcyc);
        logic aw_ok, w_ok;
        int n = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        while ((s_awvalid || s_wvalid) && n < 20) begin
            aw_ok = s_awready; w_ok = s_wready;
            @(negedge clk);
            if (aw_ok) s_awvalid = 1'b0;
            if (w_ok) s_wvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
        bcyc = cyc; resp = s_bresp;
        total++;
        if (s_bvalid !== 1'b1) begin
            bad++; $display("FAIL write_timeout addr=%h bvalid=%b required 1", a, s_bvalid);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    // Returns acyc = cycle at whose end the AR handshake samples the registers.
    task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int acyc);
        logic ok;
        int n = 0;
        acyc = -1;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        while (s_arvalid && n < 20) begin
            ok = s_arready;
            if (ok) acyc = cyc;
            @(negedge clk);
            if (ok) s_arvalid = 1'b0;
            n++;
        end
        n = 0;
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        d = s_rdata; resp = s_rresp;
        total++;
        if (s_rvalid !== 1'b1) begin
            bad++; $display("FAIL read_timeout addr=%h rvalid=%b required 1", a, s_rvalid);
            s_arvalid = 1'b0;
        end
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic stop_and_clear;
        logic [1:0] r; int bc;
        bus_write(16'h0, 32'h0, 4'hF, r, bc);
        bus_write(16'h4, 32'h0, 4'hF, r, bc);
        bus_write(16'hC, 32'h1, 4'hF, r, bc);
    endtask

    task automatic test_reset;
        logic [31:0] d; logic [1:0] r; int ac;
        resetn = 1'b0;
        #90;
        total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b exp=1", s_arready); end
        total++; if (s_awready !== 1'b1) begin bad++; $display("FAIL rst_awready got=%b exp=1", s_awready); end
        total++; if (s_wready !== 1'b1) begin bad++; $display("FAIL rst_wready got=%b exp=1", s_wready); end
        total++; if (s_bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", s_bvalid); end
        total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", s_rvalid); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", timer_irq); end
        #42 resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus_read(16'(4 * i), d, r, ac);
            total++;
            if (d !== 32'h0 || r !== 2'b00) begin
                bad++; $display("FAIL rst_read addr=%0h got=%h/%b exp=00000000/00", 4 * i, d, r);
            end
        end
    endtask

    task automatic test_periodic;
        logic [31:0] d; logic [1:0] r; int e, bc, ac, n;
        bus_write(16'h8, 32'd5, 4'hF, r, bc);
        bus_write(16'h0, 32'h7, 4'hF, r, e);
        n = 0;
        while (timer_irq !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        // match visible 6 cycles after en, irq one cycle later
        total++;
        if (timer_irq !== 1'b1 || cyc != e + 7) begin
            bad++; $display("FAIL per_first_irq irq=%b offset=%0d exp irq=1 offset=7", timer_irq, cyc - e);
        end
        wait_until(e + 12);
        bus_read(16'h4, d, r, ac);
        total++;
        if (d !== 32'((ac - e) % 6)) begin
            bad++; $display("FAIL per_count got=%0d exp=%0d", d, (ac - e) % 6);
        end
        wait_until(e + 19);
        bus_write(16'hC, 32'h1, 4'hF, r, bc);
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL per_w1c_drop irq=%b exp=0", timer_irq); end
        n = 0;
        while (timer_irq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (timer_irq !== 1'b1 || cyc != e + 25) begin
            bad++; $display("FAIL per_reassert irq=%b offset=%0d exp irq=1 offset=25", timer_irq, cyc - e);
        end
        // W1C committed on the same edge as the match at e+30
        wait_until(e + 29);
        bus_write(16'hC, 32'h1, 4'hF, r, bc);
        bus_read(16'hC, d, r, ac);
        total++;
        if (d !== 32'h1 || ac >= e + 35) begin
            bad++; $display("FAIL w1c_collision status=%h offset=%0d exp status=1 offset<35", d, ac - e);
        end
        stop_and_clear();
    endtask

    task automatic test_prescale;
        logic [31:0] d; logic [1:0] r; int e, bc, ac;
        bus_write(16'h8, 32'd2, 4'hF, r, bc);
        bus_write(16'h0, 32'h0301, 4'hF, r, e);
        for (int k = 1; k <= 3; k++) begin
            wait_until(e + 4 * k + 1);
            bus_read(16'h4, d, r, ac);
            total++;
            if (d !== 32'(ticks(e, 3, e, ac - 1)) || d !== 32'(k)) begin
                bad++; $display("FAIL psc_count k=%0d got=%0d exp=%0d", k, d, ticks(e, 3, e, ac - 1));
            end
        end
        bus_read(16'hC, d, r, ac);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL psc_status got=%h exp=1", d); end
        total++; if (timer_irq !== 1'b0) begin bad++; $display("FAIL psc_irq got=%b exp=0", timer_irq); end
        // COUNT write committed on a tick edge (e+19)
        wait_until(e + 19);
        bus_write(16'h4, 32'h100, 4'hF, r, bc);
        bus_read(16'h4, d, r, ac);
        total++;
        if (d !== 32'h100 + 32'(ticks(e, 3, bc, ac - 1)) || bc != e + 20) begin
            bad++; $display("FAIL count_collision got=%h off=%0d exp=%h off=20", d, bc - e,
                            32'h100 + 32'(ticks(e, 3, bc, ac - 1)));
        end
        stop_and_clear();
    endtask

    task automatic test_split;
        logic [31:0] d; logic [1:0] r; int ac;
        s_wdata = 32'hAABBCC5A; s_wstrb = 4'b0001; s_wvalid = 1'b1; s_bready = 1'b0;
        @(negedge clk);
        s_wvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (s_wready !== 1'b0 || s_awready !== 1'b1 || s_bvalid !== 1'b0) begin
                bad++; $display("FAIL split_wheld wr=%b awr=%b bv=%b exp 0/1/0", s_wready, s_awready, s_bvalid);
            end
            @(negedge clk);
        end
        s_awaddr = 16'h8; s_awvalid = 1'b1;
        total++; if (s_awready !== 1'b1) begin bad++; $display("FAIL split_awready got=%b exp=1", s_awready); end
        @(negedge clk);
        s_awvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (s_bvalid !== 1'b1 || s_bresp !== 2'b00 || s_awready !== 1'b0 || s_wready !== 1'b0) begin
                bad++; $display("FAIL split_bhold k=%0d bv=%b br=%b awr=%b wr=%b exp 1/00/0/0",
                                k, s_bvalid, s_bresp, s_awready, s_wready);
            end
            @(negedge clk);
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        total++;
        if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
            bad++; $display("FAIL split_release bv=%b awr=%b wr=%b exp 0/1/1", s_bvalid, s_awready, s_wready);
        end
        bus_read(16'h8, d, r, ac);
        total++;
        if (d !== merge(32'd2, 32'hAABBCC5A, 4'b0001)) begin
            bad++; $display("FAIL split_compare got=%h exp=%h", d, merge(32'd2, 32'hAABBCC5A, 4'b0001));
        end
    endtask

    task automatic test_errors;
        logic [31:0] d; logic [1:0] r; int ac, bc;
        bus_read(16'h10, d, r, ac);
        total++; if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL err_read got=%h/%b exp=0/10", d, r); end
        bus_read(16'h800C, d, r, ac);
        total++; if (d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL err_read_hi got=%h/%b exp=0/10", d, r); end
        bus_write(16'h18, 32'hFFFFFFFF, 4'hF, r, bc);
        total++; if (r !== 2'b10) begin bad++; $display("FAIL err_write_resp got=%b exp=10", r); end
        bus_read(16'h8, d, r, ac);
        total++;
        if (d !== 32'h5A || r !== 2'b00) begin bad++; $display("FAIL err_write_nochange got=%h/%b exp=5a/00", d, r); end
    endtask

    task automatic test_random;
        logic [31:0] d; logic [1:0] r; int e, bc, ac, p, cmp, arl, ien, len, t;
        logic exp_irq;
        for (int it = 0; it < 6; it++) begin
            p = int'($urandom_range(0, 3)); cmp = int'($urandom_range(0, 7));
            arl = int'($urandom_range(0, 1)); ien = int'($urandom_range(0, 1));
            stop_and_clear();
            bus_write(16'h8, 32'(cmp), 4'hF, r, bc);
            bus_write(16'h0, 32'((p << 8) | (arl << 2) | (ien << 1) | 1), 4'hF, r, e);
            len = 2 * (cmp + 1) * (p + 1) + 4;
            for (int k = 0; k < len; k++) begin
                exp_irq = (ien == 1) && (ticks(e, p, e, cyc - 2) >= cmp + 1);
                total++;
                if (timer_irq !== exp_irq) begin
                    bad++; $display("FAIL rnd_irq it=%0d p=%0d c=%0d off=%0d got=%b exp=%b",
                                    it, p, cmp, cyc - e, timer_irq, exp_irq);
                end
                @(negedge clk);
            end
            bus_read(16'h4, d, r, ac);
            t = ticks(e, p, e, ac - 1);
            total++;
            if (d !== 32'((arl == 1) ? t % (cmp + 1) : t)) begin
                bad++; $display("FAIL rnd_count it=%0d p=%0d c=%0d ar=%0d got=%0d exp=%0d",
                                it, p, cmp, arl, d, (arl == 1) ? t % (cmp + 1) : t);
            end
            bus_read(16'hC, d, r, ac);
            t = ticks(e, p, e, ac - 1);
            total++;
            if (d !== 32'(t >= cmp + 1)) begin
                bad++; $display("FAIL rnd_status it=%0d got=%h exp=%0d", it, d, t >= cmp + 1);
            end
        end
        stop_and_clear();
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] d; logic [1:0] r; int bc, ac, n;
        bus_write(16'h0, 32'h0206, 4'hF, r, bc);
        bus_write(16'h4, 32'h1234, 4'hF, r, bc);
        bus_write(16'h8, 32'hA5, 4'hF, r, bc);
        s_araddr = 16'h4; s_arvalid = 1'b1; s_rready = 1'b0;
        @(negedge clk);
        s_arvalid = 1'b0;
        n = 0;
        while (s_rvalid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        total++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h1234) begin
            bad++; $display("FAIL midrd_hold rvalid=%b rdata=%h exp 1/00001234", s_rvalid, s_rdata);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b1 || s_rdata !== 32'h0) begin
            bad++; $display("FAIL midrd_abort rvalid=%b arready=%b rdata=%h exp 0/1/0", s_rvalid, s_arready, s_rdata);
        end
        #50;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus_read(16'(4 * i), d, r, ac);
            total++;
            if (d !== 32'h0 || r !== 2'b00) begin
                bad++; $display("FAIL midrd_regs addr=%0h got=%h/%b exp=0/00", 4 * i, d, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_prescale();
        test_split();
        test_errors();
        test_random();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/soc2_axi_timer.md
# soc2_axi_timer

Memory-mapped 32-bit timer peripheral for the soc2 system: an AXI4-lite responder that the CPU accesses through the SoC interconnect, in the `pll_clk_out_25mhz` domain. It provides the following:
- a free-running or auto-reloading up-counter with programmable prescaler;
- a compare register with a sticky match flag;
- a level interrupt output toward the CPU.

It is the target that the timer test program programs and polls.

## Interface
Parameters:
- `ADDR_W`, 16: width of the AXI address ports. Bits [3:2] select the register; bits [ADDR_W-1:4] must be zero.

Ports:
- `clk`  in  1  system clock; connected to `pll_clk_out_25mhz` at the top level.
- `resetn`  in  1  reset. Asynchronous assertion, active-low.
- `s_awaddr`  in  ADDR_W  write address.
- `s_awvalid` in 1 / `s_awready` out 1  write-address handshake.
- `s_wdata`  in  32  write data.
- `s_wstrb`  in  4  byte enables.
- `s_wvalid` in 1 / `s_wready` out 1  write-data handshake.
- `s_bresp`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- `s_bvalid` out 1 / `s_bready` in 1  write-response handshake.
- `s_araddr`  in  ADDR_W  read address.
- `s_arvalid` in 1 / `s_arready` out 1  read-address handshake.
- `s_rdata`  out  32  read data.
- `s_rresp`  out  2  read response, same encoding as `s_bresp`.
- `s_rvalid` out 1 / `s_rready` in 1  read-data handshake.
- `timer_irq`  out  1  level interrupt, equal to `STATUS.match & CTRL.irq_en`.

## Operation
Register map (all registers reset to 0):
- 0x0 `CTRL`: bit0 `en`, bit1 `irq_en`, bit2 `auto_reload`, [15:8] `prescale`. Other bits read 0 and ignore writes.
- 0x4 `COUNT`: 32-bit counter, read/write.
- 0x8 `COMPARE`: 32-bit, read/write.
- 0xC `STATUS`: bit0 `match`. Writing 1 clears the bit; writing 0 has no effect.

Write behaviour:
- Each byte is written only when its `s_wstrb` bit is set.
- A write with a nonzero address in [ADDR_W-1:4] changes no register and returns SLVERR.
- A read with such an address returns `s_rdata`=0 with SLVERR.

Prescaler and counting:
- 8-bit prescaler counter `pcnt`. While `en`=0, `pcnt` is held at 0 and `COUNT` is frozen.
- While `en`=1, a tick occurs in every cycle where `pcnt==prescale`; `pcnt` returns to 0 on the tick and increments otherwise. With `prescale`=0 there is a tick every cycle.
- On a tick with `COUNT==COMPARE`:
  - `match` is set to 1.
  - `COUNT` becomes 0 if `auto_reload`=1; otherwise it becomes `COUNT+1`.
- On any other tick, `COUNT` becomes `COUNT+1`. The counter wraps from 0xFFFFFFFF to 0 with no flag.
- The match period with auto-reload is (COMPARE+1)·(prescale+1) cycles.

Simultaneous events:
- A bus write to `COUNT` in the same cycle as a tick: the write wins. The match check still uses the pre-write value.
- A W1C clear of `match` in the same cycle as a new match: set wins, `match` stays 1.
- A write to `CTRL` takes effect from the next cycle. Clearing `en` does not clear `match`.

## Timing
- Reset values: all registers, `pcnt`, `timer_irq`, `s_bvalid`, `s_rvalid`, `s_rdata`, `s_bresp` and `s_rresp` are 0. `s_awready`, `s_wready` and `s_arready` are 1.
- AW and W are accepted independently:
  - `s_awready` is held at 0 once an address is captured, until the response completes.
  - `s_wready` behaves the same way once data is captured.
  - Both readies are 0 while `s_bvalid`=1.
- The write commits at the clock edge that ends the cycle in which both address and data are held, counting either a handshake in that cycle or an earlier capture. `s_bvalid` rises at that same edge, i.e. 1 cycle of latency when AW and W arrive together.
- `s_bvalid` and `s_bresp` are held until `s_bready`=1. The next AW/W can be accepted in the cycle after the B handshake.
- `s_arready` = `~s_rvalid`. An AR accepted in cycle N gives `s_rvalid`=1 in N+1, with `s_rdata` sampled from register state at the end of cycle N. Data is held stable until `s_rready`=1.
- Reads and writes run concurrently and independently.
- `timer_irq` is registered: it rises the cycle after `match` sets and falls the cycle after the clear.
- An asynchronous reset mid-transaction drops all valids and pending captures immediately. No response is produced for an aborted transaction.

## Test plan
- Reset: hold `resetn`=0 for 132 ns, then release.
  - Before the release (during reset), the bench requires `s_arready`=1, `s_bvalid`=0, `s_rvalid`=0 and `timer_irq`=0.
  - After the release, reads of 0x0, 0x4, 0x8 and 0xC return 0 with OKAY.
- Periodic match:
  - Setup: COMPARE=5, then CTRL=0x7 (`prescale` 0).
  - `match` sets exactly 6 cycles after `en` goes high, and `COUNT` returns to 0.
  - `timer_irq`=1 the next cycle.
  - W1C of STATUS drops `timer_irq`, and it reasserts 6 cycles later.
- Prescaler and no reload:
  - Setup: CTRL=0x0301 (prescale 3, no reload), COMPARE=2.
  - `COUNT` increments every 4 cycles.
  - After the match, `COUNT` reads 3, and `timer_irq` stays 0 while `STATUS` reads 1.
- Split write and backpressure:
  - Stimulus: W issued 3 cycles before AW, with `s_wstrb`=4'b0001 and data 0xAABBCC5A to COMPARE; `s_bready` held 0 for 4 cycles.
  - COMPARE reads 0x0000005A.
  - `s_bvalid` is stable throughout, and `s_awready`/`s_wready` stay 0 until the B handshake.
- Error and collision cases:
  - A read of 0x10 returns SLVERR with data 0.
  - A write to COUNT (0x100) in the same cycle as a tick leaves `COUNT`=0x100.
  - A W1C in the same cycle as a match leaves `STATUS`=1.
- Reset mid-read: assert `resetn`=0 while `s_rvalid`=1 and `s_rready`=0 → `s_rvalid`=0 immediately, and all registers read 0 after release.
